texture_filter_stream: RTL and testbench

Parametrised, back-pressured bilinear texture filter for the texture pipeline. It accepts four neighbouring texels plus S/T sub-texel fractions per beat and returns one filtered texel. It supports four filter modes per beat, has configurable channel count and width, and uses valid/ready handshakes on both sides. It sits between the texture cache read stage and the texture environment/colour combiner, and stalls cleanly when downstream is not ready.

---
 rtl/texture_filter_stream_pkg.sv | 20 ++
 rtl/texture_filter_stream_if.sv | 42 ++++
 rtl/texture_filter_stream_lerp.sv | 59 +++++
 rtl/texture_filter_stream.sv | 163 ++++++++++++++++
 tb/tb_texture_filter_stream.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/texture_filter_stream_pkg.sv
// texture_filter_pkg
// Shared definitions for the bilinear texture filter stream.
// - Filter-mode encodings, as carried on s_mode.
// - Width helper for the per-channel lerp intermediate.
package texture_filter_pkg;

  typedef logic [1:0] filter_mode_t;

  localparam filter_mode_t MODE_NEAREST  = 2'd0;
  localparam filter_mode_t MODE_BILINEAR = 2'd1;
  localparam filter_mode_t MODE_LINEAR_S = 2'd2;
  localparam filter_mode_t MODE_LINEAR_T = 2'd3;

  // a*(2^F - f) + b*f + 2^(F-1) peaks at (2^CW - 1) * 2^F + 2^(F-1),
  // so a single guard bit above CW+F is sufficient.
  function automatic int lerp_width(input int channel_width, input int sub_width);
    return channel_width + sub_width + 1;
  endfunction

endpackage

// File: rtl/texture_filter_stream_if.sv
// texture_filter_stream_if
// Input and output valid/ready streams of the texture filter.
//   s_valid/s_ready    input beat handshake
//   s_mode             filter mode (texture_filter_pkg MODE_*)
//   s_texel00..11      neighbour texels, index [T][S]
//   s_sub_s/s_sub_t    sub-texel fractions toward texel x1 / 1x
//   m_valid/m_ready    output beat handshake
//   m_texel            filtered texel
// The slave modport is the filter's view; master is the producer/consumer view.
interface texture_filter_stream_if #(
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int SUB_WIDTH     = 8
);
  localparam int PIXEL_WIDTH = CHANNELS * CHANNEL_WIDTH;

  logic                   s_valid;
  logic                   s_ready;
  logic [1:0]             s_mode;
  logic [PIXEL_WIDTH-1:0] s_texel00;
  logic [PIXEL_WIDTH-1:0] s_texel01;
  logic [PIXEL_WIDTH-1:0] s_texel10;
  logic [PIXEL_WIDTH-1:0] s_texel11;
  logic [SUB_WIDTH-1:0]   s_sub_s;
  logic [SUB_WIDTH-1:0]   s_sub_t;
  logic                   m_valid;
  logic                   m_ready;
  logic [PIXEL_WIDTH-1:0] m_texel;

  modport slave (
    input  s_valid, s_mode, s_texel00, s_texel01, s_texel10, s_texel11,
           s_sub_s, s_sub_t, m_ready,
    output s_ready, m_valid, m_texel
  );

  modport master (
    output s_valid, s_mode, s_texel00, s_texel01, s_texel10, s_texel11,
           s_sub_s, s_sub_t, m_ready,
    input  s_ready, m_valid, m_texel
  );

endinterface

// File: rtl/texture_filter_stream_lerp.sv
// texel_lerp
// One-cycle registered per-channel linear interpolation of two texels:
//   y = (a*(2^F - f) + b*f + 2^(F-1)) >> F, independently per channel.
// Ports:
//   aclk, resetn  clock, async active-low reset (y clears to 0)
//   ce            load enable for the output register
//   a, b          texel vectors, CHANNELS x CHANNEL_WIDTH
//   f             fraction toward b; f = 0 returns a exactly
//   y             registered result
module texel_lerp
  import texture_filter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int SUB_WIDTH     = 8
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic                                ce,
  input  logic [CHANNELS*CHANNEL_WIDTH-1:0]   a,
  input  logic [CHANNELS*CHANNEL_WIDTH-1:0]   b,
  input  logic [SUB_WIDTH-1:0]                f,
  output logic [CHANNELS*CHANNEL_WIDTH-1:0]   y
);

  localparam int PIXEL_WIDTH = CHANNELS * CHANNEL_WIDTH;
  localparam int LW          = lerp_width(CHANNEL_WIDTH, SUB_WIDTH);

  logic [PIXEL_WIDTH-1:0] y_d;
  logic [PIXEL_WIDTH-1:0] y_q;
  logic [LW-1:0]          f_w;
  logic [LW-1:0]          f_inv_w;

  assign f_w     = LW'(f);
  assign f_inv_w = (LW'(1) << SUB_WIDTH) - f_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LW-1:0] a_w;
    logic [LW-1:0] b_w;
    logic [LW-1:0] acc_w;

    assign a_w   = LW'(a[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
    assign b_w   = LW'(b[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
    assign acc_w = a_w * f_inv_w + b_w * f_w + (LW'(1) << (SUB_WIDTH - 1));
    // Weighted sum never exceeds max(a,b) after the shift, so truncation is exact.
    assign y_d[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = CHANNEL_WIDTH'(acc_w >> SUB_WIDTH);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      y_q <= '0;
    end else if (ce) begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/texture_filter_stream.sv
// texture_filter_stream
// Three-stage back-pressured bilinear texture filter.
//   A: capture texels and mode-selected fractions fs/ft
//   B: r0 = lerp(t00, t01, fs), r1 = lerp(t10, t11, fs); ft carried along
//   C: m_texel = lerp(r0, r1, ft)
// Ports:
//   aclk    clock, rising edge
//   resetn  async active-low reset; drops all in-flight beats
//   bus     texture_filter_stream_if.slave (s_* input stream, m_* output stream)
// Each stage holds a valid flag and loads when empty or when its current
// content moves on in the same cycle, so bubbles collapse and a full pipe
// sustains one beat per cycle. Ready ripples back combinationally from m_ready.
module texture_filter_stream
  import texture_filter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int SUB_WIDTH     = 8
) (
  input logic                    aclk,
  input logic                    resetn,
  texture_filter_stream_if.slave bus
);

  localparam int PIXEL_WIDTH = CHANNELS * CHANNEL_WIDTH;

  logic valid_a_q, valid_b_q, valid_c_q;
  logic valid_a_d, valid_b_d, valid_c_d;
  logic ready_a, ready_b, ready_c;
  logic load_a, load_b, load_c;

  logic [PIXEL_WIDTH-1:0] t00_q, t01_q, t10_q, t11_q;
  logic [SUB_WIDTH-1:0]   fs_d, ft_d;
  logic [SUB_WIDTH-1:0]   fs_q, ft_q;
  logic [SUB_WIDTH-1:0]   ft_b_q;
  logic [PIXEL_WIDTH-1:0] r0_b, r1_b;
  logic [PIXEL_WIDTH-1:0] texel_c;

  // Ready chain: each stage can take a beat if it is empty or drains this cycle.
  always_comb begin
    ready_c = !valid_c_q || bus.m_ready;
    load_c  = valid_b_q && ready_c;
    ready_b = !valid_b_q || ready_c;
    load_b  = valid_a_q && ready_b;
    ready_a = !valid_a_q || ready_b;
    load_a  = bus.s_valid && bus.s_ready;
  end

  // Gated by resetn so the input side refuses beats while reset is held.
  assign bus.s_ready = resetn && ready_a;

  always_comb begin
    valid_a_d = load_a || (valid_a_q && !load_b);
    valid_b_d = load_b || (valid_b_q && !load_c);
    valid_c_d = load_c || (valid_c_q && !bus.m_ready);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      valid_c_q <= 1'b0;
    end else begin
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      valid_c_q <= valid_c_d;
    end
  end

  // A zero fraction makes the lerp return its a-operand exactly, so nearest
  // mode rides the same datapath and latency as the filtered modes.
  always_comb begin
    fs_d = '0;
    ft_d = '0;
    case (bus.s_mode)
      MODE_NEAREST: begin
        fs_d = '0;
        ft_d = '0;
      end
      MODE_BILINEAR: begin
        fs_d = bus.s_sub_s;
        ft_d = bus.s_sub_t;
      end
      MODE_LINEAR_S: begin
        fs_d = bus.s_sub_s;
        ft_d = '0;
      end
      MODE_LINEAR_T: begin
        fs_d = '0;
        ft_d = bus.s_sub_t;
      end
      default: begin
        fs_d = '0;
        ft_d = '0;
      end
    endcase
  end

  // Stage A data: contents are don't-care while valid_a_q is low.
  always_ff @(posedge aclk) begin
    if (load_a) begin
      t00_q <= bus.s_texel00;
      t01_q <= bus.s_texel01;
      t10_q <= bus.s_texel10;
      t11_q <= bus.s_texel11;
      fs_q  <= fs_d;
      ft_q  <= ft_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (load_b) begin
      ft_b_q <= ft_q;
    end
  end

  texel_lerp #(
    .CHANNELS      (CHANNELS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .SUB_WIDTH     (SUB_WIDTH)
  ) u_lerp_r0 (
    .aclk   (aclk),
    .resetn (resetn),
    .ce     (load_b),
    .a      (t00_q),
    .b      (t01_q),
    .f      (fs_q),
    .y      (r0_b)
  );

  texel_lerp #(
    .CHANNELS      (CHANNELS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .SUB_WIDTH     (SUB_WIDTH)
  ) u_lerp_r1 (
    .aclk   (aclk),
    .resetn (resetn),
    .ce     (load_b),
    .a      (t10_q),
    .b      (t11_q),
    .f      (fs_q),
    .y      (r1_b)
  );

  // Output register resets to 0, which keeps m_texel at 0 until the first beat.
  texel_lerp #(
    .CHANNELS      (CHANNELS),
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .SUB_WIDTH     (SUB_WIDTH)
  ) u_lerp_out (
    .aclk   (aclk),
    .resetn (resetn),
    .ce     (load_c),
    .a      (r0_b),
    .b      (r1_b),
    .f      (ft_b_q),
    .y      (texel_c)
  );

  assign bus.m_valid = valid_c_q;
  assign bus.m_texel = texel_c;

endmodule

// File: tb/tb_texture_filter_stream.sv
module tb_texture_filter_stream;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  texture_filter_stream_if #(.CHANNELS(4), .CHANNEL_WIDTH(8), .SUB_WIDTH(8)) bus ();

  texture_filter_stream #(.CHANNELS(4), .CHANNEL_WIDTH(8), .SUB_WIDTH(8)) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] val;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] out_log[$];
  int          lat_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          seen = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_texel = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: per-channel lerp with plain integer arithmetic, F = 8.
  function automatic int unsigned lerp1(input int unsigned a, input int unsigned b,
                                        input int unsigned f);
    return (a * (256 - f) + b * f + 128) / 256;
  endfunction

  function automatic logic [31:0] model(input logic [1:0] mode,
                                        input logic [31:0] t00, input logic [31:0] t01,
                                        input logic [31:0] t10, input logic [31:0] t11,
                                        input logic [7:0] s, input logic [7:0] t);
    int unsigned fs, ft, r0, r1, y;
    logic [31:0] res;
    fs = (mode == 2'd1 || mode == 2'd2) ? int'(s) : 0;
    ft = (mode == 2'd1 || mode == 2'd3) ? int'(t) : 0;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      r0 = lerp1(int'(t00[c*8 +: 8]), int'(t01[c*8 +: 8]), fs);
      r1 = lerp1(int'(t10[c*8 +: 8]), int'(t11[c*8 +: 8]), fs);
      y  = lerp1(r0, r1, ft);
      res[c*8 +: 8] = y[7:0];
    end
    return res;
  endfunction

  // Compare process: samples on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    if (!resetn) begin
      q.delete();
      seen = 0;
      stall_prev = 0;
      chk("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
      chk("rst_m_texel", bus.m_texel, 32'd0);
      chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
    end else begin
      chk("m_valid", {31'b0, bus.m_valid},
          {31'b0, (q.size() > 0) && (cyc >= q[0].t + 3)});
      chk("s_ready", {31'b0, bus.s_ready}, {31'b0, (q.size() < 3) || bus.m_ready});
      if (!seen && !bus.m_valid) chk("texel_zero_before_first", bus.m_texel, 32'd0);
      if (stall_prev && bus.m_valid) chk("stall_stable", bus.m_texel, prev_texel);
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("m_texel", bus.m_texel, e.val);
          out_log.push_back(bus.m_texel);
          lat_log.push_back(cyc - e.t);
          n_out++;
          seen = 1;
        end else begin
          chk("unexpected_output", {31'b0, bus.m_valid}, 32'd0);
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_t n;
        n.val = model(bus.s_mode, bus.s_texel00, bus.s_texel01, bus.s_texel10,
                      bus.s_texel11, bus.s_sub_s, bus.s_sub_t);
        n.t = cyc;
        q.push_back(n);
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_texel = bus.m_texel;
    end
  end

  task automatic send(input logic [1:0] mode, input logic [31:0] t00, input logic [31:0] t01,
                      input logic [31:0] t10, input logic [31:0] t11,
                      input logic [7:0] s, input logic [7:0] t);
    int n;
    bus.s_mode = mode;
    bus.s_texel00 = t00;
    bus.s_texel01 = t01;
    bus.s_texel10 = t10;
    bus.s_texel11 = t11;
    bus.s_sub_s = s;
    bus.s_sub_t = t;
    bus.s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (bus.s_ready || n >= 200) break;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge aclk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.m_valid) && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_timeout", {31'b0, n >= 200}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_before;
    bus.s_valid = 0;
    bus.s_mode = 0;
    bus.s_texel00 = 0;
    bus.s_texel01 = 0;
    bus.s_texel10 = 0;
    bus.s_texel11 = 0;
    bus.s_sub_s = 0;
    bus.s_sub_t = 0;
    bus.m_ready = 1;
    resetn = 0;
    repeat (3) @(posedge aclk);
    #1 resetn = 1;
    #1 chk("s_ready_after_reset", {31'b0, bus.s_ready}, 32'd1);
    @(posedge aclk);
    #1;

    // Nearest: texel00 bit-exact after 3 cycles.
    out_log.delete(); lat_log.delete();
    send(2'd0, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80, 8'h80);
    drain();
    chk("mode0_value", out_log[0], 32'h11223344);
    chk("mode0_latency", 32'(lat_log[0]), 32'd3);

    // Bilinear: every channel 0x80.
    out_log.delete(); lat_log.delete();
    send(2'd1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 8'h80, 8'h40);
    drain();
    chk("mode1_value", out_log[0], 32'h80808080);

    // Linear-S vs linear-T, back to back.
    out_log.delete(); lat_log.delete();
    send(2'd2, 32'h0, 32'hFF000000, 32'h00FF0000, 32'h0, 8'hFF, 8'hFF);
    send(2'd3, 32'h0, 32'hFF000000, 32'h00FF0000, 32'h0, 8'hFF, 8'hFF);
    drain();
    chk("mode2_value", out_log[0], 32'hFE000000);
    chk("mode3_value", out_log[1], 32'h00FE0000);
    chk("mode23_count", 32'(out_log.size()), 32'd2);

    // Back-to-back stream with m_ready high: one beat per cycle, latency 3 each.
    out_log.delete(); lat_log.delete();
    send(2'd1, 32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000, 8'h33, 8'hC0);
    send(2'd2, 32'hFF00FF00, 32'h00FF00FF, 32'h12345678, 32'h9ABCDEF0, 8'h01, 8'hFE);
    send(2'd3, 32'h01020304, 32'hFFFEFDFC, 32'hAABBCCDD, 32'h11111111, 8'h7F, 8'h81);
    send(2'd1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 8'hFF, 8'h00);
    send(2'd0, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0, 8'hFF, 8'hFF);
    drain();
    chk("stream_count", 32'(lat_log.size()), 32'd5);
    for (int i = 0; i < lat_log.size(); i++) chk("stream_latency", 32'(lat_log[i]), 32'd3);

    // Back-pressure with m_ready toggling 1-0-0-1.
    out_log.delete(); lat_log.delete();
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
               8'($urandom), 8'($urandom));
      end
      begin
        for (int i = 0; i < 80; i++) begin
          bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge aclk);
          #1;
        end
      end
    join
    bus.m_ready = 1;
    drain();
    chk("bp_count", 32'(out_log.size()), 32'd10);

    // Full pipe: simultaneous accept and pop keeps occupancy at 3.
    bus.m_ready = 0;
    send(2'd0, 32'hA0A0A0A0, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
    send(2'd0, 32'hB1B1B1B1, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
    send(2'd0, 32'hC2C2C2C2, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0);
    bus.s_valid = 1; bus.s_texel00 = 32'hD3D3D3D3; bus.s_mode = 0;
    #3 chk("full_s_ready_low", {31'b0, bus.s_ready}, 32'd0);
    chk("full_occupancy", 32'(q.size()), 32'd3);
    @(posedge aclk);
    #1 bus.m_ready = 1;
    #3 chk("full_s_ready_pop", {31'b0, bus.s_ready}, 32'd1);
    @(posedge aclk);
    #1 bus.s_valid = 0;
    chk("full_occupancy_after", 32'(q.size()), 32'd3);
    chk("full_m_valid_after", {31'b0, bus.m_valid}, 32'd1);
    drain();

    // Reset mid-stream with 3 beats in flight.
    out_log.delete(); lat_log.delete();
    send(2'd1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 8'h10, 8'h20);
    send(2'd1, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 8'h30, 8'h40);
    send(2'd1, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 8'h50, 8'h60);
    out_before = n_out;
    resetn = 0;
    #1 chk("reset_m_valid_now", {31'b0, bus.m_valid}, 32'd0);
    chk("reset_m_texel_now", bus.m_texel, 32'd0);
    @(posedge aclk);
    #1 resetn = 1;
    repeat (6) @(posedge aclk);
    #1 chk("no_stale_after_reset", 32'(n_out), 32'(out_before));
    out_log.delete(); lat_log.delete();
    send(2'd0, 32'h5A5AA5A5, 32'h0, 32'h0, 32'h0, 8'h80, 8'h80);
    drain();
    chk("post_reset_value", out_log[0], 32'h5A5AA5A5);
    chk("post_reset_latency", 32'(lat_log[0]), 32'd3);

    repeat (2) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
